serial_feeder: RTL and testbench
================================

SERIAL_FEEDER -- requirements
Module: serial_feeder

Purpose: parallel-to-serial source feeding one bit per clock into the sequence-detector FSM's `inp` input.

Interface
REQ-001 Parameter WIDTH, default 32: number of bits per loaded word (2..32).
REQ-002 Parameter LSB_FIRST, default 1: 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 load  input  1  request to capture data_in; qualified by ready.
REQ-006 data_in  input  WIDTH  word to serialize.
REQ-007 en  input  1  shift enable; low stalls the transfer.
REQ-008 ready  output  1  high when a load will be accepted.
REQ-009 ser_out  output  1  current serial bit; drives the FSM `inp`.
REQ-010 ser_valid  output  1  ser_out carries a payload bit this cycle.
REQ-011 done  output  1  one-cycle pulse after the last bit.
REQ-012 bit_cnt  output  6  number of bits already shifted out in the current word (0..WIDTH).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, and DONE.
REQ-014 ready SHALL be 1 in IDLE and DONE, and 0 in SHIFT.
REQ-015 load=1 with ready=1 at edge N SHALL capture data_in into the shift register, clear bit_cnt, and enter SHIFT at edge N.
REQ-016 In SHIFT, ser_out SHALL present the next bit in the order set by LSB_FIRST, with the first bit visible in the cycle right after the capture edge (latency 1).
REQ-017 In SHIFT with en=1, ser_valid SHALL be 1, and each rising edge SHALL advance the register by one bit and increment bit_cnt.
REQ-018 In SHIFT with en=0, ser_valid SHALL be 0, and ser_out, the register and bit_cnt SHALL hold.
REQ-019 When the edge that consumes bit WIDTH-1 occurs, the FSM SHALL enter DONE with bit_cnt=WIDTH.
REQ-020 In DONE, done SHALL be 1 and ser_valid SHALL be 0 for exactly one cycle; the next state SHALL be SHIFT if load=1, otherwise IDLE.
REQ-021 A load in DONE SHALL give back-to-back words separated by exactly one non-valid cycle.
REQ-022 load while in SHIFT SHALL be ignored without corrupting the word in flight.
REQ-023 In IDLE, ser_out, ser_valid and done SHALL be 0, and bit_cnt SHALL hold its last value.
REQ-024 The en input SHALL have no effect in IDLE or DONE; capture does not depend on en.
REQ-025 bit_cnt SHALL never exceed WIDTH and SHALL not wrap.
REQ-026 Exactly WIDTH cycles with ser_valid=1 SHALL occur per accepted load, regardless of stalls.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE with ser_out=0, ser_valid=0, done=0, bit_cnt=0, ready=1, and a cleared shift register.
REQ-028 Reset SHALL override load in the same cycle; the load is dropped.
REQ-029 Reset during SHIFT SHALL abort the word; no done pulse SHALL follow.
REQ-030 Outputs SHALL be valid (reset values) on the first edge after rst is asserted.

Verification
REQ-031 Basic transfer: WIDTH=32, LSB_FIRST=1, en=1, load data_in=32'h5772_4F6B -> ser_out=1,1,0,1,0,1,1,0,... over 32 valid cycles, then done=1 for one cycle, then ready=1.
REQ-032 MSB-first order: LSB_FIRST=0, same word -> first four bits are 0,1,0,1 and bit_cnt=32 when done is asserted.
REQ-033 Stall: en=0 for 3 cycles after bit 5 -> ser_valid=0 and ser_out, bit_cnt=5 hold for those cycles; the resumed stream is identical to the unstalled stream and still has exactly 32 valid bits.
REQ-034 Back-to-back: load 32'hFFFF_0000 asserted in the DONE cycle of the previous word -> exactly one gap cycle, then 16 zeros followed by 16 ones.
REQ-035 Ignored load and reset abort: pulse load with 32'h0 during SHIFT -> original word is unaffected; assert rst at bit 10 -> IDLE next cycle, bit_cnt=0, no done pulse.
REQ-036 End-to-end: connect ser_out to the detector FSM's inp, gated by ser_valid -> the FSM output sequence matches the golden model for 32'h5772_4F6B.

Source files
------------

// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: captures a WIDTH-bit word and presents one bit per
// enabled clock on ser_out, framed by ser_valid and closed by a one-cycle done.
module serial_feeder #(
   parameter int WIDTH     = 32,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             en,
   output logic             ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             done,
   output logic [5:0]       bit_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);

   state_t           state_r;
   logic [WIDTH-1:0] sr_r;
   logic [5:0]       cnt_r;
   logic             ready_r;
   logic             ser_out_r;
   logic             done_r;
   logic             shifting_r;
   logic [WIDTH-1:0] sr_next_s;

   // Bit that leaves the register first, in the configured order.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      if (LSB_FIRST) begin
         return w[0];
      end else begin
         return w[WIDTH-1];
      end
   endfunction

   // Register contents after one bit has been consumed.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      if (LSB_FIRST) begin
         return {1'b0, w[WIDTH-1:1]};
      end else begin
         return {w[WIDTH-2:0], 1'b0};
      end
   endfunction

   assign sr_next_s = advance(sr_r);

   // Control FSM with registered status outputs; capture ignores en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         sr_r       <= '0;
         cnt_r      <= 6'd0;
         ready_r    <= 1'b1;
         ser_out_r  <= 1'b0;
         done_r     <= 1'b0;
         shifting_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (load && ready_r) begin
                  state_r    <= SHIFT;
                  sr_r       <= data_in;
                  cnt_r      <= 6'd0;
                  ready_r    <= 1'b0;
                  ser_out_r  <= head_bit(data_in);
                  shifting_r <= 1'b1;
               end else begin
                  state_r    <= IDLE;
                  ready_r    <= 1'b1;
                  ser_out_r  <= 1'b0;
                  shifting_r <= 1'b0;
               end
            end
            SHIFT: begin
               if (en) begin
                  sr_r  <= sr_next_s;
                  cnt_r <= cnt_r + 6'd1;
                  if (cnt_r == LAST_BIT) begin
                     state_r    <= DONE;
                     ready_r    <= 1'b1;
                     done_r     <= 1'b1;
                     ser_out_r  <= 1'b0;
                     shifting_r <= 1'b0;
                  end else begin
                     ser_out_r <= head_bit(sr_next_s);
                  end
               end else begin
                  sr_r <= sr_r;
               end
            end
            default: begin
               state_r    <= IDLE;
               ready_r    <= 1'b1;
               ser_out_r  <= 1'b0;
               done_r     <= 1'b0;
               shifting_r <= 1'b0;
            end
         endcase
      end
   end

   // A stalled SHIFT cycle holds the bit but marks it as not carrying payload.
   assign ser_valid = shifting_r & en;
   assign ready     = ready_r;
   assign ser_out   = ser_out_r;
   assign done      = done_r;
   assign bit_cnt   = cnt_r;

endmodule

// File: tb/tb_serial_feeder.sv
// Bench for serial_feeder: a WIDTH=4 vector table, directed corner sequences and
// random traffic on LSB- and MSB-first WIDTH=32 instances against a queue model.
module tb_serial_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, load, en;
   logic [31:0] data_in;
   logic        ready_l, ser_out_l, ser_valid_l, done_l;
   logic        ready_m, ser_out_m, ser_valid_m, done_m;
   logic [5:0]  bit_cnt_l, bit_cnt_m;

   logic        rst_s, load_s, en_s;
   logic [3:0]  data_s;
   logic        ready_s, ser_out_s, ser_valid_s, done_s;
   logic [5:0]  bit_cnt_s;

   serial_feeder #(.WIDTH(32), .LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en),
      .ready(ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
      .done(done_l), .bit_cnt(bit_cnt_l));

   serial_feeder #(.WIDTH(32), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en),
      .ready(ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
      .done(done_m), .bit_cnt(bit_cnt_m));

   serial_feeder #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_s (
      .clk(clk), .rst(rst_s), .load(load_s), .data_in(data_s), .en(en_s),
      .ready(ready_s), .ser_out(ser_out_s), .ser_valid(ser_valid_s),
      .done(done_s), .bit_cnt(bit_cnt_s));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a queue of bits still to be sent per bit order.
   bit q_l[$];
   bit q_m[$];
   bit active   = 1'b0;
   bit done_e   = 1'b0;
   int cnt_e    = 0;
   logic [31:0] stream_l;
   logic [31:0] stream_m;
   int  vcount;
   int  done_count;

   task automatic tick();
      bit dummy;
      if (ser_valid_l === 1'b1) begin
         stream_l = {ser_out_l, stream_l[31:1]};
         vcount++;
      end
      if (ser_valid_m === 1'b1) begin
         stream_m = {stream_m[30:0], ser_out_m};
      end
      @(posedge clk);
      if (rst) begin
         active = 1'b0; done_e = 1'b0; cnt_e = 0;
         q_l.delete(); q_m.delete();
      end else if (!active) begin
         done_e = 1'b0;
         if (load) begin
            q_l.delete(); q_m.delete();
            for (int i = 0; i < 32; i++) begin
               q_l.push_back(data_in[i]);
               q_m.push_back(data_in[31-i]);
            end
            cnt_e  = 0;
            active = 1'b1;
         end
      end else if (en) begin
         dummy = q_l.pop_front();
         dummy = q_m.pop_front();
         cnt_e++;
         if (q_l.size() == 0) begin
            active = 1'b0;
            done_e = 1'b1;
         end
      end
      #1;
      if (done_l === 1'b1) done_count++;
      check("ready_l",     32'(ready_l),     32'(!active));
      check("ser_out_l",   32'(ser_out_l),   active ? 32'(q_l[0]) : 32'd0);
      check("ser_valid_l", 32'(ser_valid_l), 32'(active && en));
      check("done_l",      32'(done_l),      32'(done_e));
      check("bit_cnt_l",   32'(bit_cnt_l),   32'(cnt_e));
      check("ready_m",     32'(ready_m),     32'(!active));
      check("ser_out_m",   32'(ser_out_m),   active ? 32'(q_m[0]) : 32'd0);
      check("ser_valid_m", 32'(ser_valid_m), 32'(active && en));
      check("done_m",      32'(done_m),      32'(done_e));
      check("bit_cnt_m",   32'(bit_cnt_m),   32'(cnt_e));
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 100 && done_l !== 1'b1; i++) tick();
      check(name, 32'(done_l), 32'd1);
   endtask

   typedef struct {
      logic       r, ld, e;
      logic [3:0] d;
      logic       rdy, so, sv, dn;
      logic [5:0] cnt;
   } vec_t;

   vec_t tbl[17];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd3};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4};

      rst = 1'b1; load = 1'b0; en = 1'b0; data_in = 32'd0;
      rst_s = 1'b1; load_s = 1'b0; en_s = 1'b0; data_s = 4'd0;
      stream_l = 32'd0; stream_m = 32'd0; vcount = 0; done_count = 0;

      // Small-width vector table; outputs are checked just after each edge.
      for (int i = 0; i < 17; i++) begin
         rst_s = tbl[i].r; load_s = tbl[i].ld; en_s = tbl[i].e; data_s = tbl[i].d;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_ready", i),   32'(ready_s),     32'(tbl[i].rdy));
         check($sformatf("tbl%0d_ser_out", i), 32'(ser_out_s),   32'(tbl[i].so));
         check($sformatf("tbl%0d_valid", i),   32'(ser_valid_s), 32'(tbl[i].sv));
         check($sformatf("tbl%0d_done", i),    32'(done_s),      32'(tbl[i].dn));
         check($sformatf("tbl%0d_bit_cnt", i), 32'(bit_cnt_s),   32'(tbl[i].cnt));
      end
      rst_s = 1'b1; load_s = 1'b0;

      // Basic transfer with a three-cycle stall after bit 5.
      rst = 1'b1; tick();
      rst = 1'b0; load = 1'b1; en = 1'b1; data_in = 32'h5772_4F6B; tick();
      load = 1'b0; data_in = 32'd0;
      stream_l = 32'd0; stream_m = 32'd0; vcount = 0;
      for (int i = 0; i < 5; i++) tick();
      check("stall_start_cnt", 32'(bit_cnt_l), 32'd5);
      en = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      en = 1'b1;
      wait_done("stall_word_done");
      check("stall_stream_l", stream_l, 32'h5772_4F6B);
      check("stall_stream_m", stream_m, 32'h5772_4F6B);
      check("stall_valid_count", 32'(vcount), 32'd32);
      check("msb_done_cnt", 32'(bit_cnt_m), 32'd32);

      // Back-to-back load issued in the DONE cycle.
      load = 1'b1; data_in = 32'hFFFF_0000; tick();
      load = 1'b0; data_in = 32'd0;
      stream_l = 32'd0; vcount = 0;
      wait_done("b2b_done");
      check("b2b_stream", stream_l, 32'hFFFF_0000);
      check("b2b_valid_count", 32'(vcount), 32'd32);
      tick();
      check("idle_after_done_ready", 32'(ready_l), 32'd1);

      // Ignored load in flight, then reset at bit 10 with no done afterwards.
      load = 1'b1; data_in = 32'hA5A5_3C3C; tick();
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      load = 1'b1; data_in = 32'h0; tick();
      load = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("abort_at_cnt", 32'(bit_cnt_l), 32'd10);
      rst = 1'b1; load = 1'b1; tick();
      rst = 1'b0; load = 1'b0;
      check("abort_cnt_cleared", 32'(bit_cnt_l), 32'd0);
      done_count = 0;
      for (int i = 0; i < 40; i++) tick();
      check("abort_no_done", 32'(done_count), 32'd0);

      // Random traffic against the queue model.
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 199) == 0);
         load    = ($urandom_range(0, 3) == 0);
         en      = ($urandom_range(0, 3) != 0);
         data_in = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
